// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    typedef enum logic {
        WIN_CPU  = 1'b0,
        WIN_HOST = 1'b1
    } side_t;

    localparam logic ARB_CPU_PRI = 1'b0;
    localparam logic ARB_RR      = 1'b1;

    localparam int unsigned STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Host wait tracking: saturating wait counter, starvation escape flag and
// saturating count of grants won through that escape.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned EVT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_req,
    input  logic             host_gnt,
    input  logic             forced_win,
    output logic             escape,
    output logic [EVT_W-1:0] starve_events
);

    localparam int unsigned WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] host_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            host_wait <= '0;
        end else if (!host_req || host_gnt) begin
            host_wait <= '0;
        end else if (host_wait != WAIT_MAX) begin
            host_wait <= host_wait + 1'b1;
        end
    end

    assign escape = (host_wait >= WAIT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_events <= '0;
        end else if (forced_win && (starve_events != '1)) begin
            starve_events <= starve_events + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the CPU LSU and the AXI host path,
// with one-cycle read-return routing to the requester that issued the read.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned EVT_W        = 16
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              arb_mode,
    input  logic              cpu_halted,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    input  logic [3:0]        host_wstrb,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic [EVT_W-1:0]  starve_events
);

    owner_t win;
    owner_t rd_owner;
    side_t  last_winner;
    logic   escape;
    logic   forced_win;

    always_comb begin
        win = OWN_NONE;
        if (!S_AXI_ARESET) begin
            if (cpu_halted) begin
                if (host_req)     win = OWN_HOST;
                else if (cpu_req) win = OWN_CPU;
            end else if (cpu_req && host_req) begin
                if (arb_mode == ARB_CPU_PRI)
                    win = escape ? OWN_HOST : OWN_CPU;
                else
                    win = (last_winner == WIN_CPU) ? OWN_HOST : OWN_CPU;
            end else if (cpu_req) begin
                win = OWN_CPU;
            end else if (host_req) begin
                win = OWN_HOST;
            end
        end
    end

    assign cpu_gnt  = (win == OWN_CPU);
    assign host_gnt = (win == OWN_HOST);
    assign mem_en   = cpu_gnt | host_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wstrb = host_wstrb;
        end
    end

    // Host beating a requesting CPU in CPU-priority mode can only be the escape.
    assign forced_win = host_gnt && !cpu_halted && (arb_mode == ARB_CPU_PRI) && cpu_req;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .EVT_W        (EVT_W)
    ) u_starve (
        .clk           (S_AXI_ACLK),
        .rst           (S_AXI_ARESET),
        .host_req      (host_req),
        .host_gnt      (host_gnt),
        .forced_win    (forced_win),
        .escape        (escape),
        .starve_events (starve_events)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_owner    <= OWN_NONE;
            last_winner <= WIN_CPU;
        end else begin
            rd_owner <= (mem_en && !mem_we) ? win : OWN_NONE;
            if (win == OWN_HOST)     last_winner <= WIN_HOST;
            else if (win == OWN_CPU) last_winner <= WIN_CPU;
        end
    end

    assign cpu_rvalid  = !S_AXI_ARESET && (rd_owner == OWN_CPU);
    assign host_rvalid = !S_AXI_ARESET && (rd_owner == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a rule-level
// reference model, with the bench acting as the data memory.
module tb_dmem_port_arbiter;

    localparam int unsigned AW      = 12;
    localparam int unsigned LIMIT   = 8;
    localparam int unsigned TB_EVTW = 4;
    localparam int          EVT_MAX = (1 << TB_EVTW) - 1;

    logic              clk = 1'b0;
    logic              S_AXI_ARESET;
    logic              arb_mode, cpu_halted;
    logic              cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0]     cpu_addr, host_addr;
    logic [31:0]       cpu_wdata, host_wdata;
    logic [3:0]        cpu_wstrb, host_wstrb;
    logic              cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [31:0]       cpu_rdata, host_rdata;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;
    logic [TB_EVTW-1:0] starve_events;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIMIT),
        .EVT_W        (TB_EVTW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .arb_mode      (arb_mode),
        .cpu_halted    (cpu_halted),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_wstrb     (cpu_wstrb),
        .cpu_gnt       (cpu_gnt),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_wstrb    (host_wstrb),
        .host_gnt      (host_gnt),
        .host_rvalid   (host_rvalid),
        .host_rdata    (host_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .starve_events (starve_events)
    );

    // Reference model state: 0 = none, 1 = CPU, 2 = host
    int          m_last, m_wait, m_evt, m_pend;
    logic [31:0] mem [0:(1<<AW)-1];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_wait = 0;
        m_evt  = 0;
        m_pend = 0;
    endtask

    // Apply the currently driven inputs for one cycle and check all outputs.
    task automatic step();
        int          win;
        bit          both, forced, e_we;
        logic [AW-1:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_st;
        bit          e_crv, e_hrv;
        both = cpu_req && host_req;
        win  = 0;
        if (!S_AXI_ARESET) begin
            if (cpu_halted)                 win = host_req ? 2 : (cpu_req ? 1 : 0);
            else if (!both)                 win = cpu_req ? 1 : (host_req ? 2 : 0);
            else if (arb_mode == 1'b0)      win = (m_wait >= LIMIT) ? 2 : 1;
            else                            win = (m_last == 1) ? 2 : 1;
        end
        forced = (win == 2) && !cpu_halted && (arb_mode == 1'b0) && both;
        e_we = 0; e_addr = '0; e_wd = '0; e_st = '0;
        if (win == 1) begin e_we = cpu_we;  e_addr = cpu_addr;  e_wd = cpu_wdata;  e_st = cpu_wstrb;  end
        if (win == 2) begin e_we = host_we; e_addr = host_addr; e_wd = host_wdata; e_st = host_wstrb; end
        e_crv = !S_AXI_ARESET && (m_pend == 1);
        e_hrv = !S_AXI_ARESET && (m_pend == 2);

        @(negedge clk);
        chk("cpu_gnt",     cpu_gnt,     win == 1);
        chk("host_gnt",    host_gnt,    win == 2);
        chk("mem_en",      mem_en,      win != 0);
        chk("mem_we",      mem_we,      e_we);
        chk("mem_addr",    mem_addr,    e_addr);
        chk("mem_wdata",   mem_wdata,   e_wd);
        chk("mem_wstrb",   mem_wstrb,   e_st);
        chk("cpu_rvalid",  cpu_rvalid,  e_crv);
        chk("host_rvalid", host_rvalid, e_hrv);
        chk("cpu_rdata",   cpu_rdata,   e_crv ? mem_rdata : 32'h0);
        chk("host_rdata",  host_rdata,  e_hrv ? mem_rdata : 32'h0);
        chk("starve_events", starve_events, m_evt);

        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        if (S_AXI_ARESET) begin
            model_reset();
        end else begin
            if (win != 0 && e_we) begin
                for (int b = 0; b < 4; b++)
                    if (e_st[b]) mem[e_addr][8*b +: 8] = e_wd[8*b +: 8];
            end else if (win != 0) begin
                mem_rdata = mem[e_addr];
            end
            m_wait = (host_req && win != 2) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
            if (forced && m_evt < EVT_MAX) m_evt++;
            if (win != 0) m_last = win;
            m_pend = (win != 0 && !e_we) ? win : 0;
        end
    endtask

    task automatic idle_inputs();
        arb_mode = 1'b0; cpu_halted = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_wstrb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        S_AXI_ARESET = 1'b1;
        step();
        S_AXI_ARESET = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[12'h010] = 32'h12345678;
        idle_inputs();
        S_AXI_ARESET = 1'b1;
        mem_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // CPU-only read, data returned one cycle later
        cpu_req = 1'b1; cpu_addr = 12'h010;
        step();
        cpu_req = 1'b0;
        step();

        // CPU priority with both requesting: host escapes on the ninth cycle
        cpu_req = 1'b1; host_req = 1'b1; cpu_addr = 12'h020; host_addr = 12'h030;
        for (int i = 0; i < 9; i++) step();
        chk("starve_after_escape", starve_events, 1);
        idle_inputs();
        step();

        // Round robin from reset: host first
        do_reset();
        arb_mode = 1'b1; cpu_req = 1'b1; host_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_addr = AW'(i); host_addr = AW'(i + 64);
            step();
        end
        idle_inputs();
        step();

        // Halted CPU: host write with partial strobe
        cpu_halted = 1'b1; cpu_req = 1'b1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h005;
        host_wdata = 32'hDEADBEEF; host_wstrb = 4'b0011;
        step();
        idle_inputs();
        step();

        // Host read granted, then reset pulsed the following cycle
        host_req = 1'b1; host_addr = 12'h005;
        step();
        idle_inputs();
        S_AXI_ARESET = 1'b1;
        step();
        S_AXI_ARESET = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            S_AXI_ARESET = ($urandom_range(0, 49) == 0);
            arb_mode   = 1'($urandom);
            cpu_halted = ($urandom_range(0, 7) == 0);
            cpu_req    = ($urandom_range(0, 3) != 0);
            cpu_we     = 1'($urandom);
            cpu_addr   = AW'($urandom_range(0, 31));
            cpu_wdata  = $urandom;
            cpu_wstrb  = 4'($urandom);
            host_req   = ($urandom_range(0, 3) != 0);
            host_we    = 1'($urandom);
            host_addr  = AW'($urandom_range(0, 31));
            host_wdata = $urandom;
            host_wstrb = 4'($urandom);
            step();
        end

        // Drive enough forced escapes to saturate the event counter
        do_reset();
        cpu_req = 1'b1; host_req = 1'b1; host_we = 1'b1; host_wstrb = 4'hF;
        for (int i = 0; i < (EVT_MAX + 3) * (LIMIT + 1); i++) begin
            host_wdata = $urandom;
            step();
        end
        chk("starve_saturated", starve_events, EVT_MAX);
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory between the CPU load/store unit and the AXI host path. The host path is the write/read side of the AXI-Lite control slave.
- Grants at most one access per cycle.
- Routes the synchronous-read result back to the requester that issued it.
- Guarantees the host forward progress while the CPU runs.
- Sits between both requesters and the dmem macro, so the AXI slave no longer drives the memory directly.

Parameters:
ADDR_W, 12, word-address width of data memory
STARVE_LIMIT, 8, consecutive host-wait cycles before the host is forced to win (CPU-priority mode)
EVT_W, 16, width of the saturating starvation-event counter

Ports:
S_AXI_ACLK  in  1  single clock, all state on its rising edge
S_AXI_ARESET  in  1  reset, synchronous, active-high
arb_mode  in  1  0 = CPU priority with starvation escape; 1 = round robin
cpu_halted  in  1  1 = host has absolute priority
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  32  CPU write data
cpu_wstrb  in  4  CPU byte strobes
cpu_gnt  out  1  same-cycle accept of CPU request
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  32  CPU read data
host_req, host_we, host_addr, host_wdata, host_wstrb  in  1/1/ADDR_W/32/4  host request, same rules as CPU
host_gnt  out  1  same-cycle accept of host request
host_rvalid  out  1  host read data valid
host_rdata  out  32  host read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte strobes
mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1
starve_events  out  EVT_W  count of forced host wins, saturating

Behaviour:
- Reset (S_AXI_ARESET=1 at an edge) clears all registers: rd_owner=NONE, last_winner=CPU, host_wait=0, starve_events=0.
- While S_AXI_ARESET is high, all gnt, rvalid and mem_en/mem_we are forced to 0.
- Grants are combinational from the requests plus registered state. At most one gnt per cycle. gnt=1 only when the matching req=1.
- mem_en = cpu_gnt | host_gnt. mem_* fields are muxed from the winner, and are 0 when there is no winner.
- Winner selection, in priority order:
  - cpu_halted=1: host wins if host_req is high.
  - arb_mode=0: CPU wins, unless host_wait >= STARVE_LIMIT, in which case the host wins.
  - arb_mode=1 with both requesting: the winner is the opposite of last_winner.
  - Only one requesting: that requester wins in every mode.
- Mode and halt inputs take effect in the same cycle they change.
- host_wait: increments, saturating at STARVE_LIMIT, on each cycle with host_req & !host_gnt. Clears on host_gnt or when host_req=0.
- starve_events: increments, saturating at all-ones, on each grant won through the STARVE_LIMIT escape. It does not count cpu_halted grants or round-robin grants.
- last_winner updates on every grant.
- Read return:
  - A read grant (we=0) sets rd_owner to the winner for the next cycle; a write grant or no grant sets NONE.
  - X_rvalid = (rd_owner==X), registered, so latency is exactly 1 cycle after gnt.
  - X_rdata = mem_rdata when X_rvalid, else 0.
- Throughput is 1 access per cycle; back-to-back grants to the same or alternating requesters are legal.
- A write grant produces no rvalid.
- Reset asserted the cycle after a read grant suppresses that rvalid.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner encoding (OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HOST=2'd2);
  - mode constants ARB_CPU_PRI=1'b0, ARB_RR=1'b1;
  - default STARVE_LIMIT.
- One sub-module: dmem_arb_starve_ctr. It contains the host_wait counter, the escape flag (host_wait>=STARVE_LIMIT) and the saturating starve_events counter.
- Selection, muxing and read-return routing stay in the top.

Test Plan:
- CPU-only read addr 0x010, mem returns 0x12345678 -> cpu_gnt same cycle, cpu_rvalid exactly 1 cycle later with cpu_rdata=0x12345678, host_rvalid=0.
- arb_mode=0, both requesting continuously, STARVE_LIMIT=8 -> CPU granted 8 cycles, host granted in cycle 9, starve_events=1, host_wait back to 0.
- arb_mode=1, both requesting reads for 6 cycles starting after reset -> grants alternate HOST,CPU,HOST,CPU,HOST,CPU (last_winner=CPU at reset); each rvalid routed to the correct owner.
- cpu_halted=1, host writes 0xDEADBEEF strobe 4'b0011 to addr 0x005 while cpu_req=1 -> host_gnt=1, mem_wstrb=4'b0011, no rvalid, cpu_gnt=0.
- Host read granted, then S_AXI_ARESET pulsed the next cycle -> host_rvalid stays 0, all counters 0 after reset.
- Drive 2^EVT_W+2 forced escapes -> starve_events saturates at all-ones and does not wrap.
